// File: rtl/spi_ram_master.sv
// spi_ram_master
// ---------------------------------------------------------------------------
// Host-side SPI master for the SPI-slave/RAM subsystem. A parallel command
// {cmd_op, cmd_data} becomes a 10-bit frame shifted MSB first on MOSI while
// SS_n is low. For a read-data command (op 11) the master waits RD_LAT cycles
// after the last MOSI bit, then samples 8 MISO bits. It returns the byte on
// rsp_data with a one-cycle rsp_valid pulse.
// The SPI bit clock is clk itself: one bit per clk cycle.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both 1. cmd_ready is 1 only in IDLE. The host holds
// cmd_valid/cmd_op/cmd_data stable until that edge, and may change them
// afterwards. rsp_valid is a single-cycle pulse with no backpressure.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready command handshake
//   cmd_op[1:0]         frame bits [9:8]: 00 wr addr, 01 wr data,
//                       10 rd addr, 11 rd data
//   cmd_data[7:0]       frame bits [7:0]
//   rsp_valid           one-cycle pulse, read reply valid
//   rsp_data[7:0]       last read reply, held until the next reply
//   busy                high whenever the FSM is not in IDLE
//   SS_n, MOSI, MISO    SPI pins
//   state_dbg[2:0]      current FSM state, for checkers
//   frame_cnt[15:0]     frames completed (only with SPI_RAM_MASTER_FRAME_CNT_EN)
//
// Optional feature macro: SPI_RAM_MASTER_FRAME_CNT_EN adds the frame_cnt
// output, a wrapping count of frames that reached GAP.
// ---------------------------------------------------------------------------
module spi_ram_master #(
   parameter int LEAD   = 1,  // SS_n-low, MOSI=0 cycles before bit 9 (0-7)
   parameter int RD_LAT = 1,  // cycles between last MOSI bit and first MISO sample (0-7)
   parameter int GAP    = 1   // SS_n-high cycles after a frame (1-7)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [7:0]  cmd_data,
   output logic        rsp_valid,
   output logic [7:0]  rsp_data,
   output logic        busy,
   output logic        SS_n,
   output logic        MOSI,
   input  logic        MISO,
   output logic [2:0]  state_dbg
`ifdef SPI_RAM_MASTER_FRAME_CNT_EN
   ,
   output logic [15:0] frame_cnt
`endif
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEAD  = 3'd1,
      S_SHIFT = 3'd2,
      S_WAIT  = 3'd3,
      S_RECV  = 3'd4,
      S_GAP   = 3'd5
   } state_t;

   // Counter reload values: each phase counts down to zero and is reloaded
   // on entry to the next phase, so no counter ever wraps.
   localparam logic [3:0] LEAD_LD = (LEAD   > 0) ? 4'(LEAD - 1)   : 4'd0;
   localparam logic [3:0] WAIT_LD = (RD_LAT > 0) ? 4'(RD_LAT - 1) : 4'd0;
   localparam logic [3:0] GAP_LD  = (GAP    > 0) ? 4'(GAP - 1)    : 4'd0;

   state_t      state;
   logic [9:0]  frame;   // outgoing frame; bit 9 is always the next bit to send
   logic        rd_op;   // latched "op == 11" for the frame in flight
   logic [3:0]  cnt;     // down-counter for the current phase
   logic [7:0]  rx_sh;   // MISO shift register, first sample ends in bit 7

   assign state_dbg = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         frame     <= '0;
         rd_op     <= 1'b0;
         cnt       <= '0;
         rx_sh     <= '0;
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         busy      <= 1'b0;
         SS_n      <= 1'b1;
         MOSI      <= 1'b0;
`ifdef SPI_RAM_MASTER_FRAME_CNT_EN
         frame_cnt <= '0;
`endif
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               cmd_ready <= 1'b1;
               SS_n      <= 1'b1;
               MOSI      <= 1'b0;
               busy      <= 1'b0;
               if (cmd_valid && cmd_ready) begin
                  frame     <= {cmd_op, cmd_data};
                  rd_op     <= (cmd_op == 2'b11);
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  SS_n      <= 1'b0;
                  if (LEAD == 0) begin
                     // No lead-in: the first SHIFT cycle drives bit 9 directly.
                     state <= S_SHIFT;
                     MOSI  <= cmd_op[1];
                     cnt   <= 4'd9;
                  end else begin
                     state <= S_LEAD;
                     MOSI  <= 1'b0;
                     cnt   <= LEAD_LD;
                  end
               end
            end

            S_LEAD: begin
               if (cnt == 4'd0) begin
                  state <= S_SHIFT;
                  MOSI  <= frame[9];
                  cnt   <= 4'd9;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end

            S_SHIFT: begin
               if (cnt == 4'd0) begin
                  MOSI <= 1'b0;
                  if (rd_op) begin
                     if (RD_LAT == 0) begin
                        state <= S_RECV;
                        cnt   <= 4'd7;
                     end else begin
                        state <= S_WAIT;
                        cnt   <= WAIT_LD;
                     end
                  end else begin
                     state <= S_GAP;
                     SS_n  <= 1'b1;
                     cnt   <= GAP_LD;
`ifdef SPI_RAM_MASTER_FRAME_CNT_EN
                     frame_cnt <= frame_cnt + 16'd1;
`endif
                  end
               end else begin
                  // frame[9] is on the wire now; frame[8] goes out next.
                  MOSI  <= frame[8];
                  frame <= {frame[8:0], 1'b0};
                  cnt   <= cnt - 4'd1;
               end
            end

            S_WAIT: begin
               if (cnt == 4'd0) begin
                  state <= S_RECV;
                  cnt   <= 4'd7;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end

            S_RECV: begin
               rx_sh <= {rx_sh[6:0], MISO};
               if (cnt == 4'd0) begin
                  rsp_data  <= {rx_sh[6:0], MISO};
                  rsp_valid <= 1'b1;
                  state     <= S_GAP;
                  SS_n      <= 1'b1;
                  cnt       <= GAP_LD;
`ifdef SPI_RAM_MASTER_FRAME_CNT_EN
                  frame_cnt <= frame_cnt + 16'd1;
`endif
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end

            S_GAP: begin
               if (cnt == 4'd0) begin
                  state     <= S_IDLE;
                  cmd_ready <= 1'b1;
                  busy      <= 1'b0;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end

            default: begin
               state     <= S_IDLE;
               SS_n      <= 1'b1;
               MOSI      <= 1'b0;
               cmd_ready <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_ram_master.sv
// Testbench for spi_ram_master with default parameters (LEAD=1, RD_LAT=1,
// GAP=1). A behavioural SPI-slave/RAM model answers read-data frames. It
// drives random MISO outside the reply window.
// Expected frames and replies are queued when commands are issued. Negedge
// monitors pop and compare them when SS_n rises or rsp_valid pulses.
module tb_spi_ram_master;

   localparam int LEAD   = 1;
   localparam int RD_LAT = 1;
   localparam int GAP    = 1;

   typedef struct packed {
      logic [9:0] bits;
      logic [7:0] len;
   } fexp_t;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [7:0]  cmd_data;
   logic        rsp_valid;
   logic [7:0]  rsp_data;
   logic        busy;
   logic        SS_n;
   logic        MOSI;
   logic        MISO;
   logic [2:0]  state_dbg;
`ifdef SPI_RAM_MASTER_FRAME_CNT_EN
   logic [15:0] frame_cnt;
`endif

   spi_ram_master #(.LEAD(LEAD), .RD_LAT(RD_LAT), .GAP(GAP)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .busy      (busy),
      .SS_n      (SS_n),
      .MOSI      (MOSI),
      .MISO      (MISO),
      .state_dbg (state_dbg)
`ifdef SPI_RAM_MASTER_FRAME_CNT_EN
      ,
      .frame_cnt (frame_cnt)
`endif
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int          n_vec = 0;
   int          n_err = 0;
   logic [7:0]  exp_q[$];        // expected read replies
   fexp_t       exp_frame_q[$];  // expected frames on the wire
   logic [15:0] exp_fc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: event not expected or not seen (t=%0t)", name, $time);
   endtask

   // ---------------- SPI-slave / RAM model ----------------
   logic [7:0] mem [256];
   logic [7:0] s_addr = 8'h00;
   logic [9:0] s_fr;
   logic [7:0] s_reply;
   logic       s_rd;
   int         s_idx;
   logic       force_stream = 1'b0;
   logic [7:0] stream_byte  = 8'h00;

   always @(negedge clk) begin
      if (!rst_n || SS_n) begin
         s_idx = 0;
         s_fr  = '0;
         s_rd  = 1'b0;
         MISO  = 1'($urandom_range(0, 1));
      end else begin
         if (s_idx >= LEAD && s_idx < LEAD + 10) s_fr = {s_fr[8:0], MOSI};
         if (s_idx == LEAD + 9) begin
            case (s_fr[9:8])
               2'b00: s_addr = s_fr[7:0];
               2'b01: mem[s_addr] = s_fr[7:0];
               2'b10: s_addr = s_fr[7:0];
               default: begin
                  s_rd    = 1'b1;
                  s_reply = force_stream ? stream_byte : mem[s_addr];
               end
            endcase
         end
         if (s_rd && s_idx >= LEAD + 10 + RD_LAT && s_idx < LEAD + 18 + RD_LAT)
            MISO = s_reply[7 - (s_idx - (LEAD + 10 + RD_LAT))];
         else
            MISO = 1'($urandom_range(0, 1));  // must be ignored by the DUT
         s_idx++;
      end
   end

   // ---------------- monitor: frames and replies ----------------
   int         m_idx = 0;
   int         m_hi  = 0;
   logic       in_frame = 1'b0;
   logic       had_frame = 1'b0;
   logic       m_nz = 1'b0;
   logic [9:0] m_got = '0;

   always @(negedge clk) begin
      fexp_t      f;
      logic [7:0] e;
      if (!rst_n) begin
         in_frame  = 1'b0;
         had_frame = 1'b0;
         m_idx     = 0;
         m_hi      = 0;
         exp_fc    = '0;
      end else begin
         if (rsp_valid) begin
            // The reply pulse lands on the first SS_n-high cycle after the frame.
            chk("rsp_in_first_gap_cycle", {30'd0, SS_n, in_frame}, 32'd3);
            if (exp_q.size() == 0) fail("rsp_unexpected");
            else begin
               e = exp_q.pop_front();
               chk("rsp_data", rsp_data, e);
            end
         end
         if (!SS_n) begin
            if (!in_frame) begin
               if (had_frame) chk("ss_high_ge_gap", 32'(m_hi >= GAP), 1);
               in_frame = 1'b1;
               m_idx    = 0;
               m_got    = '0;
               m_nz     = 1'b0;
            end
            if (m_idx >= LEAD && m_idx < LEAD + 10) m_got = {m_got[8:0], MOSI};
            else if (MOSI) m_nz = 1'b1;
            m_idx++;
         end else begin
            if (in_frame) begin
               in_frame  = 1'b0;
               had_frame = 1'b1;
               m_hi      = 0;
               exp_fc    = exp_fc + 16'd1;
               if (exp_frame_q.size() == 0) fail("frame_unexpected");
               else begin
                  f = exp_frame_q.pop_front();
                  chk("frame_bits", m_got, f.bits);
                  chk("ss_low_len", m_idx, f.len);
                  chk("mosi_zero_outside_bits", m_nz, 0);
               end
            end
            m_hi++;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [1:0] op, input logic [7:0] d, input logic hold,
                       output int acc_at);
      fexp_t f;
      logic  acc;
      logic  ok;
      f.bits = {op, d};
      f.len  = (op == 2'b11) ? 8'(LEAD + 10 + RD_LAT + 8) : 8'(LEAD + 10);
      exp_frame_q.push_back(f);
      cmd_op    = op;
      cmd_data  = d;
      cmd_valid = 1'b1;
      ok = 1'b0;
      acc_at = -1;
      for (int t = 0; t < 200; t++) begin
         acc = cmd_ready;
         @(posedge clk);
         #1;
         if (acc) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail("cmd_accept_timeout");
      acc_at = cyc;
      // The frame in flight must not depend on the inputs after acceptance.
      cmd_data = 8'($urandom_range(0, 255));
      if (!hold) cmd_valid = 1'b0;
   endtask

   task automatic send_rd(input logic [7:0] exp_byte);
      int a;
      exp_q.push_back(exp_byte);
      send(2'b11, 8'h00, 1'b0, a);
   endtask

   task automatic wait_idle();
      logic ok;
      ok = 1'b0;
      for (int t = 0; t < 500; t++) begin
         @(negedge clk);
         if (!busy && SS_n && exp_frame_q.size() == 0 && exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail("idle_timeout");
   endtask

   // ---------------- stimulus ----------------
   int a0, a1, a2, a3;

   initial begin
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_data  = 8'h00;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;

      // Reset values.
      repeat (3) @(negedge clk);
      chk("rst_ss_n", SS_n, 1);
      chk("rst_mosi", MOSI, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_cmd_ready", cmd_ready, 0);
`ifdef SPI_RAM_MASTER_FRAME_CNT_EN
      chk("rst_frame_cnt", frame_cnt, 0);
`endif
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("ready_after_rst", cmd_ready, 1);

      // Single write-address frame 00_1010_0101: 11 cycles low, then 1 high.
      send(2'b00, 8'hA5, 1'b0, a0);
      chk("busy_after_accept", busy, 1);
      repeat (11) @(posedge clk);
      #1;
      chk("gap_ss_n_high", SS_n, 1);
      chk("gap_not_ready", cmd_ready, 0);
      @(posedge clk);
      #1;
      chk("idle_ready_back", cmd_ready, 1);
      chk("idle_busy_low", busy, 0);
      wait_idle();

      // Write 3C to address 10 and read it back.
      send(2'b00, 8'h10, 1'b0, a0);
      send(2'b01, 8'h3C, 1'b0, a0);
      send(2'b10, 8'h10, 1'b0, a0);
      send_rd(8'h3C);
      wait_idle();

      // Slave drives 1,0,1,1,0,0,1,0 in the reply window -> B2, 20 cycles low.
      force_stream = 1'b1;
      stream_byte  = 8'hB2;
      send_rd(8'hB2);
      wait_idle();
      force_stream = 1'b0;

      // Three writes with cmd_valid held high: 13-cycle command spacing.
      send(2'b00, 8'h07, 1'b1, a1);
      send(2'b01, 8'h5A, 1'b1, a2);
      send(2'b00, 8'h08, 1'b0, a3);
      chk("b2b_spacing_1", a2 - a1, 13);
      chk("b2b_spacing_2", a3 - a2, 13);
      wait_idle();
      send(2'b10, 8'h07, 1'b0, a0);
      send_rd(8'h5A);
      wait_idle();

      // Abort a read-data frame at SHIFT bit 4; frame 11_0001_0000 has bit 4 = 1.
      send(2'b11, 8'h10, 1'b0, a0);
      repeat (6) @(posedge clk);
      #2;
      chk("abort_mosi_bit4", MOSI, 1);
      rst_n = 1'b0;
      exp_frame_q.delete();
      #1;
      chk("abort_ss_n_async", SS_n, 1);
      chk("abort_busy", busy, 0);
      chk("abort_ready", cmd_ready, 0);
      chk("abort_rsp_valid", rsp_valid, 0);
`ifdef SPI_RAM_MASTER_FRAME_CNT_EN
      chk("abort_frame_cnt", frame_cnt, 0);
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (25) @(negedge clk);  // any late reply would hit rsp_unexpected
      send(2'b10, 8'h10, 1'b0, a0);
      send_rd(8'h3C);
      wait_idle();

      chk("exp_q_drained", exp_q.size(), 0);
      chk("frame_q_drained", exp_frame_q.size(), 0);
`ifdef SPI_RAM_MASTER_FRAME_CNT_EN
      chk("frame_cnt", frame_cnt, exp_fc);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/spi_ram_master.md
Name: spi_ram_master

Overview:
- Upstream driver for the SPI-slave/RAM subsystem: converts parallel host commands into 10-bit SPI frames on MOSI/SS_n and, for read-data commands, captures the 8-bit reply from MISO.
- SPI bit clock is the system clock `clk`: one bit per `clk` cycle, no divider.
- Sits between a host/testbench-side command interface and the `spi` top's MOSI/SS_n/MISO pins.

Parameters:
- LEAD, 1, cycles SS_n is held low with MOSI=0 before frame bit 9 is driven (range 0-7).
- RD_LAT, 1, cycles between the last MOSI bit and the first MISO sample on a read-data frame (range 0-7).
- GAP, 1, minimum cycles SS_n is held high after a frame before the next command is accepted (range 1-7).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  host command present
- cmd_ready  output  1  block can accept a command
- cmd_op  input  2  frame bits [9:8]: 00 wr addr, 01 wr data, 10 rd addr, 11 rd data
- cmd_data  input  8  frame bits [7:0] (address, write data, or don't-care for op 11)
- rsp_valid  output  1  one-cycle pulse, read reply valid
- rsp_data  output  8  read reply byte, held until next reply
- busy  output  1  high whenever state != IDLE
- SS_n  output  1  slave select, active low
- MOSI  output  1  serial data to slave, MSB first
- MISO  input  1  serial data from slave

Behaviour:
- Clock: single clock `clk`. Reset: asynchronous active-low `rst_n`.
- Reset values: SS_n=1, MOSI=0, cmd_ready=0 while rst_n=0, rsp_valid=0, rsp_data=0, busy=0, state=IDLE.
- Reset mid-frame forces SS_n=1 immediately (asynchronous), aborts the frame, and emits no rsp_valid.
- All outputs are registered and change only on the rising edge of `clk`, except for asynchronous reset.
- States: IDLE, LEAD, SHIFT, WAIT, RECV, GAP.
- IDLE:
  - cmd_ready=1, SS_n=1, MOSI=0.
  - On an edge with cmd_valid=1: load shift register {cmd_op,cmd_data}, latch op, go to LEAD (or SHIFT if LEAD=0).
  - cmd_ready=0 in every other state; commands presented while busy are held off, not dropped.
- LEAD: SS_n=0, MOSI=0 for exactly LEAD cycles.
- SHIFT:
  - SS_n=0 for exactly 10 cycles; MOSI = frame bit 9 in the first cycle down to bit 0 in the tenth.
  - Exit to WAIT (op 11) or GAP (other ops).
- WAIT: SS_n=0, MOSI=0 for RD_LAT cycles (skipped if RD_LAT=0).
- RECV:
  - SS_n=0, MOSI=0 for 8 cycles; MISO is sampled on each rising edge, first sample = rsp_data[7].
  - On the 8th sample edge: rsp_data updated, rsp_valid=1 for one cycle, go to GAP.
- GAP:
  - SS_n=1, MOSI=0 for GAP cycles, then IDLE.
  - rsp_valid pulse coincides with the first GAP cycle.
- SS_n low duration per frame:
  - Write/rd-addr: exactly LEAD+10 cycles.
  - Read-data: LEAD+10+RD_LAT+8 cycles.
  - Never glitches high inside a frame.
- Command-to-command throughput:
  - Write: 1+LEAD+10+GAP cycles.
  - Back-to-back commands with cmd_valid held high are accepted on the first IDLE edge after GAP.
- Bit counters wrap nowhere; each is reloaded on state entry.
- cmd_op/cmd_data may change after acceptance without affecting the frame in flight.
- MISO is ignored outside RECV.

Optional Feature:
- Macro: SPI_RAM_MASTER_FRAME_CNT_EN.
- Defined:
  - Adds output port frame_cnt[15:0], reset 0.
  - Increments by 1 on the cycle a frame enters GAP (all ops); wraps 16'hFFFF->0.
  - Reset mid-frame clears it and does not count the aborted frame.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset → SS_n=1, MOSI=0, busy=0, rsp_valid=0, rsp_data=0; then cmd_ready=1 after rst_n deassert.
- cmd_op=00, cmd_data=8'hA5, defaults → SS_n low 11 cycles; MOSI = 0, then 0,0,1,0,1,0,0,1,0,1; SS_n high 1 cycle; cmd_ready back at IDLE.
- Write addr 8'h10, write data 8'h3C, rd addr 8'h10, rd data (cmd_data=0), through real spi slave/RAM → rsp_valid single pulse, rsp_data=8'h3C.
- Model MISO stream 1,0,1,1,0,0,1,0 during RECV with op 11 → rsp_data=8'hB2; SS_n low exactly 20 cycles.
- cmd_valid held high across 3 write commands → each accepted only when cmd_ready=1; no frame overlap; SS_n high ≥ GAP cycles between frames.
- rst_n asserted at SHIFT bit 4 of a read-data frame → SS_n=1 asynchronously, no rsp_valid; next command completes normally.
